nodeio_rr: RTL and testbench
============================

Name: nodeio_rr

Overview:
- Parametrised successor to the node IO block of a TIS-100-style compute node. It sits between the node core (MOV/ADD source and destination accesses) and NPORTS neighbour channels.
- It resolves explicit-port, ANY, LAST and NIL accesses, completing one word per handshake.
- Over the previous generation it adds:
  - a configurable channel count and data width;
  - fair round-robin arbitration for ANY reads;
  - a rotating one-hot scan for ANY writes;
  - correct LAST semantics, where LAST is the last port completed via ANY;
  - NIL and LAST-before-valid handling.

Parameters:
- NPORTS, 4, number of neighbour channels (2..8).
- WIDTH, 11, data word width (two's complement).
- IDXW, $clog2(NPORTS), port index width (derived; do not override).

Ports:
- CLK  in  1  clock.
- nRST  in  1  synchronous, active-low reset.
- dir_mode  in  2  access mode: PORT / ANY / LAST / NIL.
- dir_idx  in  IDXW  port index; used only in PORT mode.
- tx  in  1  core requests a write of out_data; held high until tx_complete.
- rx  in  1  core requests a read; held high until rx_complete.
- out_data  in  WIDTH  word to transmit.
- in_data  out  WIDTH  received word; valid when rx_complete=1.
- tx_complete  out  1  single-cycle write done.
- rx_complete  out  1  single-cycle read done.
- p_wdata  out  NPORTS*WIDTH  write data to each neighbour (all copies equal out_data).
- p_wen  out  NPORTS  write offer, at most one bit set.
- p_wack  in  NPORTS  neighbour accepted our write.
- p_rdata  in  NPORTS*WIDTH  data offered by each neighbour.
- p_ren  in  NPORTS  neighbour has data for us.
- p_rack  out  NPORTS  we consumed the neighbour's data, at most one bit set.
- last_idx  out  IDXW  registered LAST port.
- last_valid  out  1  last_idx is meaningful.

Behaviour:
- Clock and reset: one clock, CLK. Reset nRST is synchronous and active-low.
- Reset state and outputs during reset:
  - While nRST=0, every combinational output is forced to 0: p_wen, p_rack, tx_complete, rx_complete, in_data.
  - On a CLK edge with nRST=0: scan_ptr<=0, rr_ptr<=0, last_idx<=0, last_valid<=0.
  - Reset mid-transfer drops the request silently. The core re-issues it.
- Latency: all completions are combinational in the cycle the condition holds (0-cycle). Registers update at the following edge.
- Priority when tx and rx are both high: rx is serviced and tx is ignored that cycle. This is a core-side illegal condition and is flagged by an assertion.
- PORT mode, port i=dir_idx; dir_idx >= NPORTS is treated as NIL:
  - tx: p_wen[i]=1; tx_complete=p_wack[i].
  - rx: rx_complete=p_ren[i]; p_rack[i]=rx_complete; in_data=p_rdata[i].
- ANY rx:
  - Candidates are the set bits of p_ren.
  - Winner is the first set bit at or after rr_ptr, wrapping modulo NPORTS.
  - If a winner exists: rx_complete=1, p_rack[winner]=1, in_data=p_rdata[winner].
  - At the edge: rr_ptr<=(winner+1) mod NPORTS.
- ANY tx:
  - p_wen one-hot at scan_ptr; tx_complete=p_wack[scan_ptr].
  - On completion scan_ptr holds. Otherwise scan_ptr<=(scan_ptr+1) mod NPORTS each cycle tx stays high.
  - scan_ptr does not move while tx=0.
- LAST update: any ANY completion sets last_idx<=winner (rx) or scan_ptr (tx) and last_valid<=1. PORT, LAST and NIL completions do not modify last_idx.
- LAST mode:
  - last_valid=1: behaves as PORT with i=last_idx.
  - last_valid=0: behaves as NIL.
- NIL mode: tx_complete=tx; rx_complete=rx; in_data=0; no port strobes.
- Wrap-around: pointers wrap using a compare against NPORTS-1, not a power-of-two overflow, so non-power-of-two NPORTS is handled.
- Port signals not selected by the current access are 0.
- Invariants (asserted):
  - $onehot0(p_wen) and $onehot0(p_rack).
  - tx_complete and rx_complete are never both 1.

Decomposition:
- Shared package types_pkg:
  - add dir_mode_t enum {DIR_PORT=2'd0, DIR_ANY=2'd1, DIR_LAST=2'd2, DIR_NIL=2'd3};
  - add localparam TIS_WIDTH=11.
- Sub-module rr_pick #(N): inputs req[N] and ptr; outputs found and idx. It is purely combinational, rotate-then-priority-encode, and is reusable by the future stack/IO nodes.
- nodeio_rr keeps the pointers, the LAST registers and the mode mux.

Test Plan:
1. PORT rx, dir_idx=2, p_ren=4'b0100, p_rdata[2]=11'd123 -> same cycle rx_complete=1, p_rack=4'b0100, in_data=123; last_valid stays 0.
2. ANY rx, rr_ptr=0, p_ren=4'b1010 held for two requests -> first grant port 1, then port 3 (rr_ptr 2→0); last_idx=3, last_valid=1.
3. ANY tx, neighbour 2 acks only on its cycle -> p_wen sequence 0001, 0010, 0100; tx_complete in cycle 3; scan_ptr holds 2; last_idx=2.
4. LAST before any ANY: tx with out_data=-5 -> immediate tx_complete, p_wen=0. After test 3, LAST rx with p_ren[2]=1 and p_rdata=999 -> in_data=999.
5. NIL rx -> rx_complete=1, in_data=0. Simultaneous tx=rx=1 in PORT 0 -> only rx serviced and assertion fires.
6. NPORTS=3 build: ANY tx scan wraps 0,1,2,0. nRST=0 mid-scan at ptr=2 -> next edge scan_ptr=0, last_valid=0, all outputs 0 during reset.

Source files
------------

// File: rtl/nodeio_rr_pkg.sv
// Shared types for the TIS-style node blocks: access-mode encoding and the native word width.
package nodeio_rr_pkg;

    typedef enum logic [1:0] {
        DIR_PORT = 2'd0,
        DIR_ANY  = 2'd1,
        DIR_LAST = 2'd2,
        DIR_NIL  = 2'd3
    } dir_mode_t;

    localparam int unsigned TIS_WIDTH = 11;

endpackage

// File: rtl/nodeio_rr_if.sv
// Core-side access and neighbour-channel bundle of the node IO block.
interface nodeio_rr_if
    import nodeio_rr_pkg::*;
#(
    parameter int unsigned NPORTS = 4,
    parameter int unsigned WIDTH  = TIS_WIDTH
);
    localparam int unsigned IDXW = $clog2(NPORTS);

    dir_mode_t                dir_mode;
    logic [IDXW-1:0]          dir_idx;
    logic                     tx;
    logic                     rx;
    logic [WIDTH-1:0]         out_data;
    logic [WIDTH-1:0]         in_data;
    logic                     tx_complete;
    logic                     rx_complete;
    logic [NPORTS*WIDTH-1:0]  p_wdata;
    logic [NPORTS-1:0]        p_wen;
    logic [NPORTS-1:0]        p_wack;
    logic [NPORTS*WIDTH-1:0]  p_rdata;
    logic [NPORTS-1:0]        p_ren;
    logic [NPORTS-1:0]        p_rack;
    logic [IDXW-1:0]          last_idx;
    logic                     last_valid;

    modport slave (
        input  dir_mode, dir_idx, tx, rx, out_data, p_wack, p_rdata, p_ren,
        output in_data, tx_complete, rx_complete, p_wdata, p_wen, p_rack, last_idx, last_valid
    );

    modport master (
        output dir_mode, dir_idx, tx, rx, out_data, p_wack, p_rdata, p_ren,
        input  in_data, tx_complete, rx_complete, p_wdata, p_wen, p_rack, last_idx, last_valid
    );

endinterface

// File: rtl/nodeio_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping modulo N.
module rr_pick #(
    parameter  int unsigned N = 4,
    localparam int unsigned W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0] i_req,
    input  logic [W-1:0] i_ptr,
    output logic         o_found,
    output logic [W-1:0] o_idx
);

    int unsigned w_pos;

    // ptr < N and k < N, so one conditional subtract replaces a modulo.
    always_comb begin
        o_found = 1'b0;
        o_idx   = '0;
        w_pos   = 0;
        for (int unsigned k = 0; k < N; k++) begin
            w_pos = 32'(i_ptr) + k;
            if (w_pos >= N) w_pos = w_pos - N;
            if (!o_found && i_req[W'(w_pos)]) begin
                o_found = 1'b1;
                o_idx   = W'(w_pos);
            end
        end
    end

endmodule

// File: rtl/nodeio_rr.sv
// Node IO block: resolves PORT/ANY/LAST/NIL accesses against NPORTS neighbour channels.
module nodeio_rr
    import nodeio_rr_pkg::*;
#(
    parameter int unsigned NPORTS = 4,
    parameter int unsigned WIDTH  = TIS_WIDTH
) (
    input logic         CLK,
    input logic         nRST,
    nodeio_rr_if.slave  bus
);

    localparam int unsigned IDXW = $clog2(NPORTS);

    logic [IDXW-1:0]   r_scan_ptr;
    logic [IDXW-1:0]   r_rr_ptr;
    logic [IDXW-1:0]   r_last_idx;
    logic              r_last_valid;

    logic [WIDTH-1:0]  w_rdata [NPORTS];
    logic              w_found;
    logic [IDXW-1:0]   w_win;
    logic [IDXW-1:0]   w_sel;
    logic              w_idx_ok;
    logic              w_port_ok;
    logic [NPORTS-1:0] w_wen;
    logic [NPORTS-1:0] w_rack;
    logic              w_txc;
    logic              w_rxc;
    logic [WIDTH-1:0]  w_in;

    function automatic logic [IDXW-1:0] wrap_inc(input logic [IDXW-1:0] x);
        return (x == IDXW'(NPORTS - 1)) ? '0 : x + 1'b1;
    endfunction

    always_comb begin
        for (int unsigned i = 0; i < NPORTS; i++) begin
            w_rdata[i] = bus.p_rdata[i*WIDTH +: WIDTH];
        end
    end

    rr_pick #(.N(NPORTS)) u_pick (
        .i_req   (bus.p_ren),
        .i_ptr   (r_rr_ptr),
        .o_found (w_found),
        .o_idx   (w_win)
    );

    // LAST reuses the PORT datapath; an out-of-range index or an unset LAST falls back to NIL.
    assign w_idx_ok  = ({1'b0, bus.dir_idx} < (IDXW+1)'(NPORTS));
    assign w_sel     = (bus.dir_mode == DIR_LAST) ? r_last_idx : bus.dir_idx;
    assign w_port_ok = (bus.dir_mode == DIR_PORT) ? w_idx_ok : r_last_valid;

    always_comb begin
        w_wen  = '0;
        w_rack = '0;
        w_txc  = 1'b0;
        w_rxc  = 1'b0;
        w_in   = '0;
        if (nRST && bus.rx) begin
            case (bus.dir_mode)
                DIR_PORT, DIR_LAST: begin
                    if (w_port_ok) begin
                        w_rxc         = bus.p_ren[w_sel];
                        w_rack[w_sel] = bus.p_ren[w_sel];
                        w_in          = w_rdata[w_sel];
                    end else begin
                        w_rxc = 1'b1;
                    end
                end
                DIR_ANY: begin
                    if (w_found) begin
                        w_rxc         = 1'b1;
                        w_rack[w_win] = 1'b1;
                        w_in          = w_rdata[w_win];
                    end
                end
                default: w_rxc = 1'b1;
            endcase
        end else if (nRST && bus.tx) begin
            case (bus.dir_mode)
                DIR_PORT, DIR_LAST: begin
                    if (w_port_ok) begin
                        w_wen[w_sel] = 1'b1;
                        w_txc        = bus.p_wack[w_sel];
                    end else begin
                        w_txc = 1'b1;
                    end
                end
                DIR_ANY: begin
                    w_wen[r_scan_ptr] = 1'b1;
                    w_txc             = bus.p_wack[r_scan_ptr];
                end
                default: w_txc = 1'b1;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            r_scan_ptr   <= '0;
            r_rr_ptr     <= '0;
            r_last_idx   <= '0;
            r_last_valid <= 1'b0;
        end else if (bus.rx) begin
            if (bus.dir_mode == DIR_ANY && w_found) begin
                r_rr_ptr     <= wrap_inc(w_win);
                r_last_idx   <= w_win;
                r_last_valid <= 1'b1;
            end
        end else if (bus.tx && bus.dir_mode == DIR_ANY) begin
            if (bus.p_wack[r_scan_ptr]) begin
                r_last_idx   <= r_scan_ptr;
                r_last_valid <= 1'b1;
            end else begin
                r_scan_ptr <= wrap_inc(r_scan_ptr);
            end
        end
    end

    assign bus.p_wdata     = {NPORTS{bus.out_data}};
    assign bus.p_wen       = w_wen;
    assign bus.p_rack      = w_rack;
    assign bus.tx_complete = w_txc;
    assign bus.rx_complete = w_rxc;
    assign bus.in_data     = w_in;
    assign bus.last_idx    = r_last_idx;
    assign bus.last_valid  = r_last_valid;

    always_ff @(posedge CLK) begin
        if (nRST) begin
            assert ($onehot0(w_wen)) else $error("p_wen not one-hot: %b", w_wen);
            assert ($onehot0(w_rack)) else $error("p_rack not one-hot: %b", w_rack);
            assert (!(w_txc && w_rxc)) else $error("tx_complete and rx_complete both high");
            assert (!(bus.tx && bus.rx)) else $warning("core drove tx and rx together; tx ignored");
        end
    end

endmodule

// File: tb/tb_nodeio_rr.sv
// Directed bench for nodeio_rr: a 4-port and a 3-port instance driven through one linear sequence.
module tb_nodeio_rr;
    import nodeio_rr_pkg::*;

    logic clk = 1'b0;
    logic rst4;
    logic rst3;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    nodeio_rr_if #(.NPORTS(4), .WIDTH(11)) b4 ();
    nodeio_rr_if #(.NPORTS(3), .WIDTH(11)) b3 ();

    nodeio_rr #(.NPORTS(4), .WIDTH(11)) u_dut4 (.CLK(clk), .nRST(rst4), .bus(b4));
    nodeio_rr #(.NPORTS(3), .WIDTH(11)) u_dut3 (.CLK(clk), .nRST(rst3), .bus(b3));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    initial begin
        rst4 = 1'b0;
        rst3 = 1'b0;
        b4.dir_mode = DIR_NIL; b4.dir_idx = '0; b4.tx = 1'b1; b4.rx = 1'b1;
        b4.out_data = 11'd77; b4.p_wack = 4'b1111; b4.p_rdata = '1; b4.p_ren = 4'b1111;
        b3.dir_mode = DIR_ANY; b3.dir_idx = '0; b3.tx = 1'b0; b3.rx = 1'b0;
        b3.out_data = '0; b3.p_wack = '0; b3.p_rdata = '0; b3.p_ren = '0;

        // Reset: combinational outputs forced low even with requests pending
        @(posedge clk); @(posedge clk);
        @(negedge clk); #1;
        chk("rst_rx_complete", 32'(b4.rx_complete), 0);
        chk("rst_tx_complete", 32'(b4.tx_complete), 0);
        chk("rst_p_rack",      32'(b4.p_rack), 0);
        chk("rst_p_wen",       32'(b4.p_wen), 0);
        chk("rst_in_data",     32'(b4.in_data), 0);
        chk("rst_last_valid",  32'(b4.last_valid), 0);
        chk("rst_last_idx",    32'(b4.last_idx), 0);

        @(negedge clk);
        b4.tx = 1'b0; b4.rx = 1'b0; b4.p_wack = '0; b4.p_ren = '0; b4.p_rdata = '0;
        rst4 = 1'b1;
        rst3 = 1'b1;

        // PORT rx on port 2
        @(negedge clk);
        b4.dir_mode = DIR_PORT; b4.dir_idx = 2'd2; b4.p_ren = 4'b0100;
        b4.p_rdata[2*11 +: 11] = 11'd123; b4.rx = 1'b1;
        #1;
        chk("port_rx_complete", 32'(b4.rx_complete), 1);
        chk("port_rx_rack",     32'(b4.p_rack), 32'b0100);
        chk("port_rx_data",     32'(b4.in_data), 123);
        chk("port_rx_txc",      32'(b4.tx_complete), 0);
        @(negedge clk);
        b4.rx = 1'b0;
        #1;
        chk("port_rx_last_valid", 32'(b4.last_valid), 0);

        // PORT rx on a port with nothing offered
        @(negedge clk);
        b4.dir_idx = 2'd1; b4.rx = 1'b1;
        #1;
        chk("port_rx_idle_rxc",  32'(b4.rx_complete), 0);
        chk("port_rx_idle_rack", 32'(b4.p_rack), 0);
        @(negedge clk);
        b4.rx = 1'b0;

        // LAST tx before any ANY completion behaves as NIL
        @(negedge clk);
        b4.dir_mode = DIR_LAST; b4.out_data = 11'h7FB; b4.tx = 1'b1; b4.p_wack = 4'b1111;
        #1;
        chk("last_nil_txc",   32'(b4.tx_complete), 1);
        chk("last_nil_wen",   32'(b4.p_wen), 0);
        chk("wdata_copy3",    32'(b4.p_wdata[3*11 +: 11]), 32'h7FB);
        @(negedge clk);
        b4.tx = 1'b0; b4.p_wack = '0;
        #1;
        chk("last_nil_keeps_valid", 32'(b4.last_valid), 0);

        // ANY rx round-robin over ports 1 and 3
        @(negedge clk);
        b4.dir_mode = DIR_ANY; b4.p_ren = 4'b1010;
        b4.p_rdata[1*11 +: 11] = 11'd11; b4.p_rdata[3*11 +: 11] = 11'd33; b4.rx = 1'b1;
        #1;
        chk("any_rx1_rack", 32'(b4.p_rack), 32'b0010);
        chk("any_rx1_data", 32'(b4.in_data), 11);
        chk("any_rx1_rxc",  32'(b4.rx_complete), 1);
        @(negedge clk); #1;
        chk("any_rx2_rack", 32'(b4.p_rack), 32'b1000);
        chk("any_rx2_data", 32'(b4.in_data), 33);
        chk("any_rx2_last", 32'(b4.last_idx), 1);
        @(negedge clk);
        b4.rx = 1'b0;
        #1;
        chk("any_rx_last_idx",   32'(b4.last_idx), 3);
        chk("any_rx_last_valid", 32'(b4.last_valid), 1);
        @(negedge clk);
        b4.p_ren = 4'b0000; b4.rx = 1'b1;
        #1;
        chk("any_rx_none_rxc", 32'(b4.rx_complete), 0);
        b4.p_ren = 4'b1010;
        #1;
        chk("any_rx_wrap_rack", 32'(b4.p_rack), 32'b0010);
        @(negedge clk);
        b4.rx = 1'b0; b4.p_ren = '0;

        // ANY tx scan: neighbour 2 is the only one that acknowledges
        @(negedge clk);
        b4.p_wack = 4'b0100; b4.out_data = 11'd7; b4.tx = 1'b1;
        #1;
        chk("any_tx_c1_wen", 32'(b4.p_wen), 32'b0001);
        chk("any_tx_c1_txc", 32'(b4.tx_complete), 0);
        @(negedge clk); #1;
        chk("any_tx_c2_wen", 32'(b4.p_wen), 32'b0010);
        chk("any_tx_c2_txc", 32'(b4.tx_complete), 0);
        @(negedge clk); #1;
        chk("any_tx_c3_wen", 32'(b4.p_wen), 32'b0100);
        chk("any_tx_c3_txc", 32'(b4.tx_complete), 1);
        @(negedge clk);
        b4.tx = 1'b0; b4.p_wack = '0;
        #1;
        chk("any_tx_last_idx", 32'(b4.last_idx), 2);
        @(negedge clk); @(negedge clk);
        b4.tx = 1'b1;
        #1;
        chk("any_tx_scan_hold", 32'(b4.p_wen), 32'b0100);
        #1;
        b4.tx = 1'b0;

        // LAST rx follows port 2
        @(negedge clk);
        b4.dir_mode = DIR_LAST; b4.p_ren = 4'b0100; b4.p_rdata[2*11 +: 11] = 11'd999; b4.rx = 1'b1;
        #1;
        chk("last_rx_rxc",  32'(b4.rx_complete), 1);
        chk("last_rx_data", 32'(b4.in_data), 999);
        chk("last_rx_rack", 32'(b4.p_rack), 32'b0100);
        @(negedge clk);
        b4.rx = 1'b0;
        #1;
        chk("last_rx_keeps_idx", 32'(b4.last_idx), 2);

        // NIL accesses
        @(negedge clk);
        b4.dir_mode = DIR_NIL; b4.p_ren = 4'b1111; b4.rx = 1'b1;
        #1;
        chk("nil_rxc",  32'(b4.rx_complete), 1);
        chk("nil_data", 32'(b4.in_data), 0);
        chk("nil_rack", 32'(b4.p_rack), 0);
        b4.rx = 1'b0; b4.tx = 1'b1;
        #1;
        chk("nil_txc", 32'(b4.tx_complete), 1);
        chk("nil_wen", 32'(b4.p_wen), 0);
        #1;
        b4.tx = 1'b0;

        // tx and rx together: rx wins
        @(negedge clk);
        b4.dir_mode = DIR_PORT; b4.dir_idx = 2'd0; b4.p_ren = 4'b0001; b4.p_wack = 4'b0001;
        b4.p_rdata[0 +: 11] = 11'd55; b4.tx = 1'b1; b4.rx = 1'b1;
        #1;
        chk("both_rxc",  32'(b4.rx_complete), 1);
        chk("both_txc",  32'(b4.tx_complete), 0);
        chk("both_wen",  32'(b4.p_wen), 0);
        chk("both_rack", 32'(b4.p_rack), 32'b0001);
        chk("both_data", 32'(b4.in_data), 55);
        @(negedge clk);
        b4.tx = 1'b0; b4.rx = 1'b0;

        // 3-port instance: out-of-range PORT index, ANY rx wrap, ANY tx scan wrap, reset mid-scan
        @(negedge clk);
        b3.dir_mode = DIR_PORT; b3.dir_idx = 2'd3; b3.p_ren = 3'b111; b3.p_rdata = '1; b3.rx = 1'b1;
        #1;
        chk("n3_idx3_rxc",  32'(b3.rx_complete), 1);
        chk("n3_idx3_data", 32'(b3.in_data), 0);
        chk("n3_idx3_rack", 32'(b3.p_rack), 0);
        @(negedge clk);
        b3.dir_mode = DIR_ANY; b3.p_ren = 3'b100;
        #1;
        chk("n3_any_rx_p2", 32'(b3.p_rack), 32'b100);
        @(negedge clk);
        b3.p_ren = 3'b101;
        #1;
        chk("n3_any_rx_wrap", 32'(b3.p_rack), 32'b001);
        @(negedge clk);
        b3.rx = 1'b0; b3.p_ren = '0;
        #1;
        chk("n3_last_valid", 32'(b3.last_valid), 1);
        @(negedge clk);
        b3.tx = 1'b1;
        #1; chk("n3_scan0", 32'(b3.p_wen), 32'b001);
        @(negedge clk); #1; chk("n3_scan1", 32'(b3.p_wen), 32'b010);
        @(negedge clk); #1; chk("n3_scan2", 32'(b3.p_wen), 32'b100);
        @(negedge clk); #1; chk("n3_scan0_wrap", 32'(b3.p_wen), 32'b001);
        @(negedge clk); #1; chk("n3_scan1b", 32'(b3.p_wen), 32'b010);
        @(negedge clk); #1; chk("n3_scan2b", 32'(b3.p_wen), 32'b100);
        rst3 = 1'b0;
        #1;
        chk("n3_rst_wen", 32'(b3.p_wen), 0);
        chk("n3_rst_txc", 32'(b3.tx_complete), 0);
        @(negedge clk); #1;
        chk("n3_rst_last_valid", 32'(b3.last_valid), 0);
        chk("n3_rst_last_idx",   32'(b3.last_idx), 0);
        rst3 = 1'b1;
        #1;
        chk("n3_post_rst_scan", 32'(b3.p_wen), 32'b001);
        @(negedge clk);
        b3.tx = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
